sig_result_collector: RTL and testbench
=======================================

Name: sig_result_collector

Overview:
- Consumer-side partner of the sigmoid activation units (sig_4/8/12/16_hw).
- Tracks operands issued to the activation unit (start pulses) and accepts its y_out/valid results.
- Classifies each FP32 result, buffers it in a show-ahead FIFO and presents it downstream with valid/ready.
- Provides a credit signal (issue_ok) so the issuer never has more results in flight than the FIFO can absorb.

Parameters:
- DWIDTH, 32, result word width (IEEE-754 single).
- DEPTH, 8, FIFO entries; must be a power of two, >=2.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue  in  1  start pulse as driven to the activation unit; one operand per high cycle.
- issue_ok  out  1  credit available; issuer may assert issue this cycle.
- y_in  in  DWIDTH  activation result (y_out of the activation unit).
- y_valid  in  1  result strobe (valid of the activation unit).
- m_data  out  DWIDTH  head-of-FIFO result.
- m_flags  out  4  {neg, nan, sat_one, sat_zero} for m_data.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  downstream accepts m_data when m_valid && m_ready.
- outstanding  out  PTR_W+1  issued operands whose results have not yet returned.
- err  out  2  sticky {overflow, issue_err}.

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers 0, outstanding=0, count=0, err=0, m_valid=0, m_data=0, m_flags=0. issue_ok becomes 1 after reset release.
- Credits: issue_ok = (count + outstanding) < DEPTH. It is combinational from registered state only.
- Accepted issue: issue && issue_ok → outstanding+1.
- issue while !issue_ok: ignored; sets err[0] (sticky).
- Result return: y_valid → outstanding-1 (saturates at 0). If y_valid arrives with outstanding==0 and the FIFO has space, the result is still written.
- Simultaneous accepted issue and y_valid: outstanding unchanged.
- FIFO write: on y_valid, if count<DEPTH or a read occurs in the same cycle. Otherwise the result is dropped and err[1] is set (sticky).
- FIFO read: m_valid && m_ready → head advances, count-1.
- Simultaneous read and write: count unchanged. At full this is legal; at empty the written word appears on the next cycle.
- Pointers wrap modulo DEPTH.
- Latency: y_valid sampled at edge n → m_valid/m_data/m_flags valid after edge n (visible in cycle n+1). m_data is stable while m_valid && !m_ready.
- Classification is computed at write time and stored alongside the data:
  - neg = y[31];
  - nan = (y[30:23]==8'hFF) && (y[22:0]!=0);
  - sat_one = (y==32'h3F800000);
  - sat_zero = (y[30:0]==0).
- No state machine beyond the counters; the FIFO is the only storage.
- Reset mid-operation: all in-flight results are forgotten; results returning after reset release are written and flagged normally.

Optional Feature:
- SIG_COLLECT_STATS_EN defined: adds output ports stat_total (16 bits, results written), stat_sat (16 bits, results with sat_one or sat_zero) and stat_nan (16 bits). The counters saturate at 16'hFFFF, clear on reset, and increment on the same edge as the FIFO write; dropped results are not counted.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single result: issue pulse, then y_valid with y_in=32'h3F400000 four cycles later, m_ready=1 → m_valid=1 for one cycle, m_data=32'h3F400000, m_flags=4'b0000; outstanding goes 1→0.
- Saturation classes: results 32'h3F800000, 32'h00000000, 32'h7FC80000, 32'hBF000000 → m_flags 0010, 0001, 0100, 1000 respectively.
- Credit exhaustion: 8 issues with m_ready=0 → issue_ok=0 after the 8th; a 9th issue sets err[0]=1 and leaves outstanding=8.
- Full FIFO: 8 results buffered, m_ready=0, extra forced y_valid with y_in=32'h3F000000 → err[1]=1, count stays 8, head data unchanged. Then m_ready=1 drains 8 words in order.
- Simultaneous read/write at full: m_ready=1 and y_valid on the same cycle → no error; count stays 8; order preserved.
- Reset mid-stream: rst=0 with 3 outstanding and 2 buffered → m_valid=0, outstanding=0, err=0 immediately (asynchronous), issue_ok=1.

Source files
------------

// File: rtl/sig_result_collector.sv
// sig_result_collector: collects FP32 results from a sigmoid activation unit,
// classifies each word, buffers it in a show-ahead FIFO and hands it downstream
// with valid/ready. It also issues credits so the issuer can never have more
// results in flight than the FIFO can absorb.
// Optional macro SIG_COLLECT_STATS_EN adds saturating result statistics ports.
module sig_result_collector #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    output logic              issue_ok,
    input  logic [DWIDTH-1:0] y_in,
    input  logic              y_valid,
    output logic [DWIDTH-1:0] m_data,
    output logic [3:0]        m_flags,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PTR_W:0]    outstanding,
    output logic [1:0]        err
`ifdef SIG_COLLECT_STATS_EN
    ,
    output logic [15:0]       stat_total,
    output logic [15:0]       stat_sat,
    output logic [15:0]       stat_nan
`endif
);

    localparam logic [PTR_W:0]   LP_DEPTH    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W+1:0] LP_DEPTH_W  = (PTR_W+2)'(DEPTH);

    // Flag order is {neg, nan, sat_one, sat_zero}; bit positions assume FP32.
    function automatic logic [3:0] classify(input logic [DWIDTH-1:0] y);
        logic neg, nan, one, zero;
        neg  = y[31];
        nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        one  = (y == 32'h3F80_0000);
        zero = (y[30:0] == 31'd0);
        return {neg, nan, one, zero};
    endfunction

    logic [DWIDTH+3:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [PTR_W:0]    r_outst;
    logic [1:0]        r_err;

    logic              w_rd;
    logic              w_wr;
    logic              w_iss_acc;
    logic [PTR_W+1:0]  w_credit_sum;
    logic [3:0]        w_flags_in;

    // Credit check and FIFO handshakes, all derived from registered state.
    always_comb begin
        w_credit_sum = {1'b0, r_count} + {1'b0, r_outst};
        issue_ok     = (w_credit_sum < LP_DEPTH_W);
        m_valid      = (r_count != '0);
        w_rd         = m_valid && m_ready;
        w_wr         = y_valid && ((r_count < LP_DEPTH) || w_rd);
        w_iss_acc    = issue && issue_ok;
        w_flags_in   = classify(y_in);
    end

    // Head of FIFO; outputs are forced to zero while nothing is buffered.
    always_comb begin
        m_data  = '0;
        m_flags = '0;
        if (m_valid) begin
            m_data  = r_mem[r_rd_ptr][DWIDTH-1:0];
            m_flags = r_mem[r_rd_ptr][DWIDTH+3:DWIDTH];
        end
    end

    // Result storage: data and flags written together, never reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_flags_in, y_in};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // In-flight operand counter; a return with nothing outstanding saturates at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outst <= '0;
        end else if (w_iss_acc && y_valid) begin
            r_outst <= r_outst;
        end else if (w_iss_acc) begin
            r_outst <= r_outst + (PTR_W+1)'(1);
        end else if (y_valid && (r_outst != '0)) begin
            r_outst <= r_outst - (PTR_W+1)'(1);
        end
    end

    // Sticky errors: bit 1 = result dropped on full FIFO, bit 0 = issue without credit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            if (y_valid && !w_wr)   r_err[1] <= 1'b1;
            if (issue && !issue_ok) r_err[0] <= 1'b1;
        end
    end

    assign outstanding = r_outst;
    assign err         = r_err;

`ifdef SIG_COLLECT_STATS_EN
    logic [15:0] r_stat_total;
    logic [15:0] r_stat_sat;
    logic [15:0] r_stat_nan;

    // Saturating statistics, counted only for results actually written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_total <= '0;
            r_stat_sat   <= '0;
            r_stat_nan   <= '0;
        end else if (w_wr) begin
            if (r_stat_total != 16'hFFFF) r_stat_total <= r_stat_total + 16'd1;
            if ((w_flags_in[1] || w_flags_in[0]) && (r_stat_sat != 16'hFFFF))
                r_stat_sat <= r_stat_sat + 16'd1;
            if (w_flags_in[2] && (r_stat_nan != 16'hFFFF))
                r_stat_nan <= r_stat_nan + 16'd1;
        end
    end

    assign stat_total = r_stat_total;
    assign stat_sat   = r_stat_sat;
    assign stat_nan   = r_stat_nan;
`endif

endmodule

// File: tb/tb_sig_result_collector.sv
// Bench for sig_result_collector: directed scenarios with literal expectations
// plus randomized traffic, all checked against a queue-based reference model.
module tb_sig_result_collector;

    logic        clk;
    logic        rst;
    logic        issue;
    logic        issue_ok;
    logic [31:0] y_in;
    logic        y_valid;
    logic [31:0] m_data;
    logic [3:0]  m_flags;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  outstanding;
    logic [1:0]  err;
`ifdef SIG_COLLECT_STATS_EN
    logic [15:0] stat_total, stat_sat, stat_nan;
`endif

    sig_result_collector #(.DWIDTH(32), .DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
        .y_in(y_in), .y_valid(y_valid), .m_data(m_data), .m_flags(m_flags),
        .m_valid(m_valid), .m_ready(m_ready), .outstanding(outstanding), .err(err)
`ifdef SIG_COLLECT_STATS_EN
        , .stat_total(stat_total), .stat_sat(stat_sat), .stat_nan(stat_nan)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: buffered results, in-flight count, sticky errors.
    logic [31:0] mq[$];
    int          m_outs;
    logic [1:0]  m_err;
    int          m_total, m_sat, m_nan;

    function automatic logic [3:0] ref_flags(input logic [31:0] y);
        logic [3:0] f;
        f[3] = y[31];
        f[2] = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        f[1] = (y == 32'h3F800000);
        f[0] = (y[30:0] == 0);
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_outs  = 0;
        m_err   = 2'b00;
        m_total = 0;
        m_sat   = 0;
        m_nan   = 0;
    endtask

    task automatic compare_all();
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_data", m_data, mq[0]);
            chk("m_flags", 32'(m_flags), 32'(ref_flags(mq[0])));
        end
        chk("issue_ok", 32'(issue_ok), 32'((mq.size() + m_outs) < 8));
        chk("outstanding", 32'(outstanding), 32'(m_outs));
        chk("err", 32'(err), 32'(m_err));
`ifdef SIG_COLLECT_STATS_EN
        chk("stat_total", 32'(stat_total), 32'(m_total));
        chk("stat_sat", 32'(stat_sat), 32'(m_sat));
        chk("stat_nan", 32'(stat_nan), 32'(m_nan));
`endif
    endtask

    // One clock cycle: drive inputs, update model at the edge, check at the falling edge.
    task automatic cyc(input bit iss, input bit yv, input logic [31:0] y, input bit rdy);
        bit rd, wr, ok;
        issue   = iss;
        y_valid = yv;
        y_in    = y;
        m_ready = rdy;
        @(posedge clk);
        ok = (mq.size() + m_outs) < 8;
        rd = (mq.size() != 0) && rdy;
        wr = yv && ((mq.size() < 8) || rd);
        if (iss && !ok) m_err[0] = 1'b1;
        if (yv && !wr)  m_err[1] = 1'b1;
        if (iss && ok && yv) begin
        end else if (iss && ok) begin
            m_outs++;
        end else if (yv && m_outs > 0) begin
            m_outs--;
        end
        if (rd) void'(mq.pop_front());
        if (wr) begin
            mq.push_back(y);
            if (m_total < 65535) m_total++;
            if ((ref_flags(y)[1] || ref_flags(y)[0]) && m_sat < 65535) m_sat++;
            if (ref_flags(y)[2] && m_nan < 65535) m_nan++;
        end
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; effect checked before any clock.
    task automatic async_reset();
        issue = 0; y_valid = 0; y_in = 0; m_ready = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_flags", 32'(m_flags), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_issue_ok", 32'(issue_ok), 32'd1);
        compare_all();
    endtask

    logic [31:0] vals [8];
    logic [3:0]  fexp [4];

    initial begin
        vals[0] = 32'h3F800000; vals[1] = 32'h00000000; vals[2] = 32'h7FC80000;
        vals[3] = 32'hBF000000; vals[4] = 32'h80000000; vals[5] = 32'h3F400000;
        vals[6] = 32'h7F800000; vals[7] = 32'hFFC00001;
        fexp[0] = 4'b0010; fexp[1] = 4'b0001; fexp[2] = 4'b0100; fexp[3] = 4'b1000;

        rst = 1'b0; issue = 0; y_valid = 0; y_in = 0; m_ready = 0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("init_m_valid", 32'(m_valid), 32'd0);
        chk("init_m_data", m_data, 32'd0);
        chk("init_outstanding", 32'(outstanding), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        rst = 1'b1;
        #1;
        chk("init_issue_ok", 32'(issue_ok), 32'd1);
        @(negedge clk);
        compare_all();

        // Single result round trip.
        cyc(1, 0, 0, 1);
        chk("t1_outstanding1", 32'(outstanding), 32'd1);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h3F400000, 1);
        chk("t1_m_valid", 32'(m_valid), 32'd1);
        chk("t1_m_data", m_data, 32'h3F400000);
        chk("t1_m_flags", 32'(m_flags), 32'd0);
        chk("t1_outstanding0", 32'(outstanding), 32'd0);
        cyc(0, 0, 0, 1);
        chk("t1_m_valid_after", 32'(m_valid), 32'd0);

        // Classification of saturated / special results.
        for (int i = 0; i < 4; i++) cyc(0, 1, vals[i], 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_flags", 32'(m_flags), 32'(fexp[i]));
            cyc(0, 0, 0, 1);
        end

        // Credit exhaustion.
        async_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
        chk("t3_issue_ok", 32'(issue_ok), 32'd0);
        chk("t3_outstanding", 32'(outstanding), 32'd8);
        cyc(1, 0, 0, 0);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_outstanding_hold", 32'(outstanding), 32'd8);

        // Fill, simultaneous read/write at full, overflow, drain.
        for (int i = 0; i < 8; i++) cyc(0, 1, 32'h40000000 + i, 0);
        chk("t4_outstanding", 32'(outstanding), 32'd0);
        chk("t4_head", m_data, 32'h40000000);
        cyc(0, 1, 32'h40000008, 1);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_head", m_data, 32'h40000001);
        cyc(0, 1, 32'h3F000000, 0);
        chk("t4_err_ovf", 32'(err), 32'd3);
        chk("t4_head_kept", m_data, 32'h40000001);
        chk("t4_full_no_credit", 32'(issue_ok), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            chk("t4_drain", m_data, 32'h40000000 + i);
            cyc(0, 0, 0, 1);
        end
        chk("t4_empty", 32'(m_valid), 32'd0);

        // Reset mid-stream: 3 outstanding, 2 buffered, errors set.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        cyc(0, 1, 32'h3E000000, 0);
        cyc(0, 1, 32'h3E800000, 0);
        chk("t6_outstanding", 32'(outstanding), 32'd3);
        chk("t6_err_before", 32'(err), 32'd3);
        async_reset();
        cyc(0, 1, 32'h3F800000, 1);
        chk("t6_after_flags", 32'(m_flags), 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit iss, yv, rdy;
            logic [31:0] y;
            if (i % 1000 == 999) async_reset();
            iss = ($urandom_range(99) < 45);
            yv  = ($urandom_range(99) < 40);
            rdy = ((i / 64) % 3 == 1) ? ($urandom_range(99) < 10) : ($urandom_range(99) < 65);
            y   = ($urandom_range(1) == 1) ? vals[$urandom_range(7)] : $urandom;
            cyc(iss, yv, y, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
